// File: rtl/updown_pkg.sv
// Shared definitions for the up/down guessing game.
// Pure constants and types; no logic, no latency.
// No flow control lives here.
package updown_pkg;

    // Width of targets, guesses and the LFSR
    localparam int VAL_W = 7;

    // result_code encodings
    localparam logic [1:0] RES_UP      = 2'd0;  // target > guess
    localparam logic [1:0] RES_DOWN    = 2'd1;  // target < guess
    localparam logic [1:0] RES_CORRECT = 2'd2;
    localparam logic [1:0] RES_INVALID = 2'd3;

    // game_state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;
    localparam logic [1:0] ST_LOSE = 2'd3;

    // Map a non-zero LFSR value (1..127) into 1..max_value.
    // A single subtraction is enough because max_value >= 64 keeps the result in range.
    // Smaller max_value settings give a biased but still non-zero target.
    function automatic logic [VAL_W-1:0] fold_target(input logic [VAL_W-1:0] raw,
                                                     input logic [VAL_W-1:0] max_value);
        fold_target = (raw > max_value) ? (raw - max_value) : raw;
    endfunction

endpackage

// File: rtl/updown_lfsr.sv
// 7-bit Fibonacci LFSR, polynomial x^7+x^6+1, free-running.
// Advances on every clock edge; value is the registered state.
// No backpressure: it never stalls, and a non-zero seed keeps it off the all-zero lockup state.
module updown_lfsr
    import updown_pkg::*;
#(
    parameter logic [VAL_W-1:0] SEED = 7'h5A
) (
    input  logic             clk,
    input  logic             reset,
    output logic [VAL_W-1:0] value
);

    logic [VAL_W-1:0] lfsr_q;
    logic [VAL_W-1:0] lfsr_d;

    // Shift left; feedback is the XOR of the taps for x^7 and x^6
    always_comb begin
        lfsr_d = {lfsr_q[VAL_W-2:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    // State register, seeded on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/guess_judge.sv
// Referee for the up/down game: holds the target, judges guesses, counts attempts.
// Latency 1: result_valid is registered and pulses the cycle after guess_ready.
// No backpressure: every guess accepted in PLAY gets exactly one result; other guesses are dropped.
module guess_judge
    import updown_pkg::*;
#(
    parameter int               MAX_VALUE    = 100,
    parameter int               MAX_ATTEMPTS = 7,
    parameter logic [VAL_W-1:0] LFSR_SEED    = 7'h5A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             target_load,
    input  logic [VAL_W-1:0] target_value,
    input  logic             guess_ready,
    input  logic [VAL_W-1:0] guess_number,
    output logic             result_valid,
    output logic [1:0]       result_code,
    output logic [3:0]       attempts,
    output logic [1:0]       game_state
);

    localparam logic [VAL_W-1:0] MAX_VAL_C = VAL_W'(MAX_VALUE);
    localparam logic [3:0]       MAX_ATT_C = 4'(MAX_ATTEMPTS);

    logic [VAL_W-1:0] lfsr_val;

    logic [VAL_W-1:0] target_q,  target_d;
    logic [1:0]       state_q,   state_d;
    logic [3:0]       att_q,     att_d;
    logic [1:0]       code_q,    code_d;
    logic             vld_q,     vld_d;

    logic             guess_bad;
    logic [3:0]       att_inc;

    updown_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_val)
    );

    assign guess_bad = (guess_number == '0) || (guess_number > MAX_VAL_C);
    assign att_inc   = att_q + 4'd1;

    // Next-state: a new game outranks any guess in the same cycle
    always_comb begin
        target_d = target_q;
        state_d  = state_q;
        att_d    = att_q;
        code_d   = code_q;
        vld_d    = 1'b0;

        if (target_load || start) begin
            // target_load wins over start so directed tests stay deterministic
            target_d = target_load ? target_value : fold_target(lfsr_val, MAX_VAL_C);
            state_d  = ST_PLAY;
            att_d    = 4'd0;
        end else if (guess_ready && (state_q == ST_PLAY)) begin
            vld_d = 1'b1;
            if (guess_bad) begin
                code_d = RES_INVALID;
            end else begin
                att_d = att_inc;
                if (guess_number == target_q) begin
                    // A hit on the last attempt still counts as a win
                    code_d  = RES_CORRECT;
                    state_d = ST_WIN;
                end else begin
                    code_d = (target_q > guess_number) ? RES_UP : RES_DOWN;
                    if (att_inc == MAX_ATT_C) state_d = ST_LOSE;
                end
            end
        end
    end

    // Game registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
            state_q  <= ST_IDLE;
            att_q    <= 4'd0;
            code_q   <= RES_UP;
            vld_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            state_q  <= state_d;
            att_q    <= att_d;
            code_q   <= code_d;
            vld_q    <= vld_d;
        end
    end

    assign result_valid = vld_q;
    assign result_code  = code_q;
    assign attempts     = att_q;
    assign game_state   = state_q;

endmodule
